// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache lookup controller: default widths, FSM
// state encoding and the address index/tag split helpers.
package cache_ctrl_pkg;

    localparam int MEM_ADDR_W   = 32;
    localparam int CACHE_ADDR_W = 10;
    localparam int DATA_W       = 512;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WAIT   = 3'd2,
        S_MREQ   = 3'd3,
        S_MWAIT  = 3'd4,
        S_FILL   = 3'd5,
        S_RESP   = 3'd6
    } state_t;

    // Width-agnostic split: callers truncate the result to their own widths.
    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int unsigned idx_w);
        return addr & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int unsigned idx_w);
        return addr >> idx_w;
    endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones; synchronous active-high
// reset and clear.
module sat_counter32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_lookup_ctrl.sv
// Request-side controller in front of a 1-way cache: lookup, refill on miss,
// return the line. Define CACHE_LOOKUP_STATS_EN to build hit/miss counters.
module cache_lookup_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int C_MEM_ADDR_WIDTH   = MEM_ADDR_W,
    parameter int C_CACHE_ADDR_WIDTH = CACHE_ADDR_W,
    parameter int C_CACHE_DATA_WIDTH = DATA_W,
    parameter int C_TAG_WIDTH        = C_MEM_ADDR_WIDTH - C_CACHE_ADDR_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [C_MEM_ADDR_WIDTH-1:0]               req_addr,
    output logic                                      resp_valid,
    input  logic                                      resp_ready,
    output logic [C_CACHE_DATA_WIDTH-1:0]             resp_data,
    output logic                                      resp_hit,
    output logic                                      cache_rd_en,
    output logic [C_CACHE_ADDR_WIDTH-1:0]             cache_rd_addr,
    output logic [C_TAG_WIDTH-1:0]                    cache_rd_din,
    input  logic                                      cache_rd_result,
    input  logic [C_CACHE_DATA_WIDTH-1:0]             cache_rd_dout,
    input  logic                                      cache_rd_valid,
    output logic                                      cache_wr_en,
    output logic [C_CACHE_ADDR_WIDTH-1:0]             cache_wr_addr,
    output logic [C_CACHE_DATA_WIDTH+C_TAG_WIDTH-1:0] cache_wr_data,
    output logic                                      mem_req_valid,
    input  logic                                      mem_req_ready,
    output logic [C_MEM_ADDR_WIDTH-1:0]               mem_req_addr,
    input  logic                                      mem_rsp_valid,
    input  logic [C_CACHE_DATA_WIDTH-1:0]             mem_rsp_data,
    output logic [31:0]                               hit_count,
    output logic [31:0]                               miss_count,
    output logic [2:0]                                state_dbg
);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both 1; valid and its payload stay stable until then.

    state_t                          state;
    logic [C_MEM_ADDR_WIDTH-1:0]     addr_q;
    logic [C_CACHE_ADDR_WIDTH-1:0]   idx_q;
    logic [C_TAG_WIDTH-1:0]          tag_q;
    logic [C_CACHE_ADDR_WIDTH-1:0]   next_idx;
    logic [C_TAG_WIDTH-1:0]          next_tag;

    assign next_idx  = C_CACHE_ADDR_WIDTH'(addr_index(64'(req_addr), C_CACHE_ADDR_WIDTH));
    assign next_tag  = C_TAG_WIDTH'(addr_tag(64'(req_addr), C_CACHE_ADDR_WIDTH));
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_hit      <= 1'b0;
            cache_rd_en   <= 1'b0;
            cache_rd_addr <= '0;
            cache_rd_din  <= '0;
            cache_wr_en   <= 1'b0;
            cache_wr_addr <= '0;
            cache_wr_data <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            addr_q        <= '0;
            idx_q         <= '0;
            tag_q         <= '0;
        end else begin
            // Cache strobes are single-cycle pulses by default.
            cache_rd_en <= 1'b0;
            cache_wr_en <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready     <= 1'b0;
                        addr_q        <= req_addr;
                        idx_q         <= next_idx;
                        tag_q         <= next_tag;
                        cache_rd_en   <= 1'b1;
                        cache_rd_addr <= next_idx;
                        cache_rd_din  <= next_tag;
                        state         <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cache_rd_valid) begin
                        if (cache_rd_result) begin
                            resp_data  <= cache_rd_dout;
                            resp_hit   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= addr_q;
                            state         <= S_MREQ;
                        end
                    end
                end
                S_MREQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= S_MWAIT;
                    end
                end
                S_MWAIT: begin
                    if (mem_rsp_valid) begin
                        resp_data     <= mem_rsp_data;
                        resp_hit      <= 1'b0;
                        cache_wr_en   <= 1'b1;
                        cache_wr_addr <= idx_q;
                        cache_wr_data <= {mem_rsp_data, tag_q};
                        state         <= S_FILL;
                    end
                end
                S_FILL: begin
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_LOOKUP_STATS_EN
    logic hit_inc;
    logic miss_inc;

    assign hit_inc  = (state == S_WAIT) && cache_rd_valid && cache_rd_result;
    assign miss_inc = (state == S_WAIT) && cache_rd_valid && !cache_rd_result;

    sat_counter32 u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter32 u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (miss_inc),
        .count (miss_count)
    );
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Directed bench for cache_lookup_ctrl with a behavioural cache and memory.
module tb_cache_lookup_ctrl;

    localparam int AW = 32;
    localparam int IW = 10;
    localparam int DW = 512;
    localparam int TW = AW - IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_hit;
    logic          cache_rd_en;
    logic [IW-1:0] cache_rd_addr;
    logic [TW-1:0] cache_rd_din;
    logic          cache_rd_result;
    logic [DW-1:0] cache_rd_dout;
    logic          cache_rd_valid;
    logic          cache_wr_en;
    logic [IW-1:0] cache_wr_addr;
    logic [DW+TW-1:0] cache_wr_data;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
    logic [2:0]    state_dbg;

    cache_lookup_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_hit        (resp_hit),
        .cache_rd_en     (cache_rd_en),
        .cache_rd_addr   (cache_rd_addr),
        .cache_rd_din    (cache_rd_din),
        .cache_rd_result (cache_rd_result),
        .cache_rd_dout   (cache_rd_dout),
        .cache_rd_valid  (cache_rd_valid),
        .cache_wr_en     (cache_wr_en),
        .cache_wr_addr   (cache_wr_addr),
        .cache_wr_data   (cache_wr_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .hit_count       (hit_count),
        .miss_count      (miss_count),
        .state_dbg       (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [599:0] got, input logic [599:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- cache and memory models, monitors ----------------
    logic [TW-1:0] m_tag  [1024];
    logic          m_vld  [1024];
    logic [DW-1:0] m_data [1024];

    int            rd_pipe = 0;
    logic [IW-1:0] rd_addr_seen;
    logic [TW-1:0] rd_din_seen;
    int            rd_cyc = 0;
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    logic [IW-1:0] wr_addr_seen;
    logic [DW+TW-1:0] wr_data_seen;
    int            ovl_err = 0;
    int            resp_seen = 0;

    int            mem_stall = 0;
    int            mem_delay = 1;
    int            mem_rsp_cnt = 0;
    logic [DW-1:0] mem_line;
    int            mem_hs_cnt = 0;
    int            mem_vld_cyc = 0;
    logic [AW-1:0] exp_mem_addr;
    int            mem_addr_err = 0;

    always @(negedge clk) begin
        // cache: result valid two negedges after the lookup strobe was seen
        if (cache_rd_valid) cache_rd_valid = 1'b0;
        if (rd_pipe > 0) begin
            rd_pipe--;
            if (rd_pipe == 0) begin
                cache_rd_valid  = 1'b1;
                cache_rd_result = m_vld[rd_addr_seen] && (m_tag[rd_addr_seen] == rd_din_seen);
                cache_rd_dout   = m_data[rd_addr_seen];
            end
        end
        if (cache_rd_en) begin
            rd_cnt++;
            rd_addr_seen = cache_rd_addr;
            rd_din_seen  = cache_rd_din;
            rd_cyc       = cyc;
            rd_pipe      = 2;
        end
        if (cache_wr_en) begin
            wr_cnt++;
            wr_addr_seen = cache_wr_addr;
            wr_data_seen = cache_wr_data;
            m_vld[cache_wr_addr]  = 1'b1;
            m_tag[cache_wr_addr]  = cache_wr_data[TW-1:0];
            m_data[cache_wr_addr] = cache_wr_data[DW+TW-1:TW];
        end
        if (cache_rd_en && cache_wr_en) ovl_err++;
        if (resp_valid) resp_seen++;

        // memory: optional stall on the request, fixed response delay
        if (mem_rsp_valid) mem_rsp_valid = 1'b0;
        if (mem_rsp_cnt > 0) begin
            mem_rsp_cnt--;
            if (mem_rsp_cnt == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_line;
            end
        end
        if (mem_req_valid) begin
            mem_vld_cyc++;
            if (mem_req_addr != exp_mem_addr) mem_addr_err++;
        end
        if (mem_req_ready) begin
            mem_req_ready = 1'b0;
            mem_rsp_cnt   = mem_delay;
            mem_hs_cnt++;
        end else if (mem_req_valid) begin
            if (mem_stall > 0) mem_stall--;
            else mem_req_ready = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    int acc_cyc;
    int lat;
    logic [DW-1:0] got_data;
    logic          got_hit;
    int            busy_rdy_err;
    int            stab_err;

    task automatic do_req(input logic [AW-1:0] a);
        int n;
        for (n = 0; n < 100 && !req_ready; n++) @(negedge clk);
        check("req_ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = a;
        acc_cyc   = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int hold);
        int n;
        @(negedge clk);
        for (n = 0; n < 300 && !resp_valid; n++) begin
            if (req_ready) busy_rdy_err++;
            @(negedge clk);
        end
        check("resp_valid_timeout", resp_valid, 1'b1);
        lat      = cyc - acc_cyc;
        got_data = resp_data;
        got_hit  = resp_hit;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_data != got_data || req_ready) stab_err++;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_txn(input logic [AW-1:0] a);
        exp_mem_addr = a;
        do_req(a);
        wait_resp(0);
    endtask

    // ---------------- main sequence ----------------
    logic [DW-1:0] line_aa;
    logic [DW-1:0] line_55;
    logic [DW-1:0] line_33;
    logic [AW-1:0] hit_addr;
    int rd0, wr0, hs0, mv0, rs0;

    initial begin
        line_aa = {64{8'hAA}};
        line_55 = {64{8'h55}};
        line_33 = {64{8'h33}};
        for (int i = 0; i < 1024; i++) m_vld[i] = 1'b0;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
        cache_rd_result = 1'b0; cache_rd_dout = '0; cache_rd_valid = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_line = '0;
        exp_mem_addr = '0; busy_rdy_err = 0; stab_err = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_rd_en", cache_rd_en, 1'b0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_state", state_dbg, 3'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1'b1);

        // hit: tag 0x12345 at index 0x005
        hit_addr = 32'h048D_1405;
        m_vld[5] = 1'b1; m_tag[5] = 22'h12345; m_data[5] = line_aa;
        rd0 = rd_cnt; wr0 = wr_cnt; hs0 = mem_hs_cnt; mv0 = mem_vld_cyc;
        run_txn(hit_addr);
        check("hit_rd_addr", rd_addr_seen, 10'h005);
        check("hit_rd_din", rd_din_seen, 22'h12345);
        check("hit_rd_latency", rd_cyc - acc_cyc, 1);
        check("hit_rd_pulses", rd_cnt - rd0, 1);
        check("hit_resp_latency", lat, 4);
        check("hit_resp_hit", got_hit, 1'b1);
        check("hit_resp_data", got_data, line_aa);
        check("hit_no_mem_req", mem_vld_cyc - mv0, 0);
        check("hit_no_wr", wr_cnt - wr0, 0);

        // miss with refill, memory answers 5 cycles after the handshake
        mem_delay = 5; mem_line = line_55;
        rd0 = rd_cnt; wr0 = wr_cnt; hs0 = mem_hs_cnt;
        run_txn(32'h0000_0C00);
        check("miss_mem_hs", mem_hs_cnt - hs0, 1);
        check("miss_wr_pulses", wr_cnt - wr0, 1);
        check("miss_wr_addr", wr_addr_seen, 10'h000);
        check("miss_wr_data", wr_data_seen, {line_55, 22'h3});
        check("miss_resp_hit", got_hit, 1'b0);
        check("miss_resp_data", got_data, line_55);

        // backpressure on memory request and on the response
        mem_stall = 4; mem_delay = 2; mem_line = line_33; resp_ready = 1'b0;
        mv0 = mem_vld_cyc; busy_rdy_err = 0; stab_err = 0;
        exp_mem_addr = 32'h0000_1404;
        do_req(32'h0000_1404);
        wait_resp(3);
        check("bp_mem_valid_cycles", mem_vld_cyc - mv0, 5);
        check("bp_resp_data", got_data, line_33);
        check("bp_resp_stable", stab_err, 0);
        check("bp_req_ready_low", busy_rdy_err, 0);

        // reset while waiting for memory; late response must be dropped
        mem_delay = 15; mem_line = line_aa;
        hs0 = mem_hs_cnt;
        exp_mem_addr = 32'h0000_2008;
        do_req(32'h0000_2008);
        for (int n = 0; n < 100 && mem_hs_cnt == hs0; n++) @(negedge clk);
        check("rstmid_mem_hs", mem_hs_cnt - hs0, 1);
        @(negedge clk);
        check("rstmid_state_mwait", state_dbg, 3'd4);
        wr0 = wr_cnt; rs0 = resp_seen;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_state_idle", state_dbg, 3'd0);
        check("rstmid_mem_valid", mem_req_valid, 1'b0);
        repeat (20) @(negedge clk);
        check("rstmid_no_wr", wr_cnt - wr0, 0);
        check("rstmid_no_resp", resp_seen - rs0, 0);
        check("rstmid_req_ready", req_ready, 1'b1);
        check("rstmid_line_not_filled", m_vld[8], 1'b0);

        // same address again is now a hit
        mem_delay = 1; hs0 = mem_hs_cnt;
        run_txn(32'h0000_0C00);
        check("rehit_resp_hit", got_hit, 1'b1);
        check("rehit_resp_data", got_data, line_55);
        check("rehit_latency", lat, 4);
        check("rehit_no_mem", mem_hs_cnt - hs0, 0);

`ifdef CACHE_LOOKUP_STATS_EN
        run_txn(hit_addr);
        run_txn(32'h0000_0C00);
        mem_line = line_33;
        run_txn(32'h0000_3000);
        run_txn(32'h0000_3404);
        check("stats_hits", hit_count, 32'd3);
        check("stats_misses", miss_count, 32'd2);
        @(negedge clk);
        force dut.u_hit_cnt.count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.u_hit_cnt.count_q;
        run_txn(hit_addr);
        check("stats_hit_saturate", hit_count, 32'hFFFF_FFFF);
        check("stats_miss_hold", miss_count, 32'd2);
`else
        check("stats_off_hits", hit_count, 32'd0);
        check("stats_off_misses", miss_count, 32'd0);
`endif

        check("rd_wr_overlap", ovl_err, 0);
        check("mem_addr_stable", mem_addr_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // hard stop in case a bounded loop is somehow bypassed
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
